// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential fixed-point divider among NUM_REQ requesters.
// Divide-by-zero requests are answered locally with a saturated quotient and never reach the divider.
module divider_arbiter #(
   parameter int unsigned N       = 32,
   parameter int unsigned Q       = 15,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned REQ_W   = 2
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic [NUM_REQ-1:0]   iReqValid,
   input  logic [NUM_REQ*N-1:0] iReqDividend,
   input  logic [NUM_REQ*N-1:0] iReqDivisor,
   output logic [NUM_REQ-1:0]   oReqAccept,
   output logic                 oRespValid,
   output logic [REQ_W-1:0]     oRespId,
   output logic [2*N:0]         oRespQuotient,
   output logic                 oRespDivZero,
   output logic                 oDivStart,
   output logic [N-1:0]         oDivDividend,
   output logic [N-1:0]         oDivDivisor,
   input  logic [2*N:0]         iDivQuotient,
   input  logic                 iDivComplete
);

   localparam int unsigned MAG_W = 2 * N;

   // The ID must address every requester and the fraction must fit the result magnitude.
   if (((1 << REQ_W) < NUM_REQ) || (Q >= MAG_W)) begin : g_param_check
      $error("divider_arbiter: inconsistent REQ_W/NUM_REQ or Q/N parameters");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   state_t             state;
   logic [REQ_W-1:0]   last;
   logic               seen_busy;

   logic               win_found;
   logic [REQ_W-1:0]   win_id;
   logic [NUM_REQ-1:0] win_oh;
   logic [N-1:0]       win_dvd;
   logic [N-1:0]       win_dvs;
   logic               win_zero;

   // Rotating priority: pass 0 scans requesters above last, pass 1 wraps around to last itself.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_oh    = '0;
      win_dvd   = '0;
      win_dvs   = '0;
      for (int unsigned p = 0; p < 2; p++) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && iReqValid[k] && ((p == 0) == (k > 32'(last)))) begin
               win_found = 1'b1;
               win_id    = REQ_W'(k);
               win_oh[k] = 1'b1;
               win_dvd   = iReqDividend[k*N +: N];
               win_dvs   = iReqDivisor[k*N +: N];
            end
         end
      end
   end

   // Sign-magnitude zero, either sign.
   assign win_zero = (win_dvs[N-2:0] == '0);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state         <= IDLE;
         last          <= REQ_W'(NUM_REQ - 1);
         seen_busy     <= 1'b0;
         oReqAccept    <= '0;
         oRespValid    <= 1'b0;
         oRespId       <= '0;
         oRespQuotient <= '0;
         oRespDivZero  <= 1'b0;
         oDivStart     <= 1'b0;
         oDivDividend  <= '0;
         oDivDivisor   <= '0;
      end else begin
         oReqAccept <= '0;
         oRespValid <= 1'b0;
         oDivStart  <= 1'b0;
         case (state)
            IDLE: begin
               // Waiting on iDivComplete drains a divider left running by an arbiter reset.
               if (win_found && iDivComplete) begin
                  oReqAccept   <= win_oh;
                  oDivDividend <= win_dvd;
                  oDivDivisor  <= win_dvs;
                  oRespId      <= win_id;
                  last         <= win_id;
                  if (win_zero) begin
                     oRespQuotient <= {win_dvd[N-1] ^ win_dvs[N-1], {MAG_W{1'b1}}};
                     oRespDivZero  <= 1'b1;
                     state         <= DONE;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               oDivStart <= 1'b1;
               seen_busy <= 1'b0;
               state     <= BUSY;
            end
            BUSY: begin
               // The complete flag still high on the start edge must not end the operation.
               if (!iDivComplete) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  oRespQuotient <= iDivQuotient;
                  oRespDivZero  <= 1'b0;
                  state         <= DONE;
               end
            end
            DONE: begin
               oRespValid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural sequential divider (busy N+Q cycles).
module tb_divider_arbiter;

   localparam int unsigned N       = 32;
   localparam int unsigned Q       = 15;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned REQ_W   = 2;
   localparam int unsigned QW      = 2 * N + 1;
   // Accept pulse to response pulse with a divider that drops complete on the edge sampling start.
   localparam int unsigned LAT     = N + Q + 4;

   localparam logic [QW-1:0] Q_2_0    = 65'h0_0000_0000_0001_0000;
   localparam logic [QW-1:0] Q_0_5    = 65'h0_0000_0000_0000_4000;
   localparam logic [QW-1:0] Q_NEG6   = 65'h1_0000_0000_0003_0000;
   localparam logic [QW-1:0] Q_0_75   = 65'h0_0000_0000_0000_6000;
   localparam logic [QW-1:0] Q_SATNEG = 65'h1_FFFF_FFFF_FFFF_FFFF;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*N-1:0] req_dividend;
   logic [NUM_REQ*N-1:0] req_divisor;
   logic [NUM_REQ-1:0]   req_accept;
   logic                 resp_valid;
   logic [REQ_W-1:0]     resp_id;
   logic [QW-1:0]        resp_quot;
   logic                 resp_dz;
   logic                 div_start;
   logic [N-1:0]         div_dividend;
   logic [N-1:0]         div_divisor;
   logic [QW-1:0]        div_q = '0;
   logic                 div_complete;

   logic [N-1:0] dvd [NUM_REQ];
   logic [N-1:0] dvs [NUM_REQ];

   int unsigned div_cnt = 0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   int            acc_id_q[$];
   int            acc_cyc_q[$];
   int            start_cyc_q[$];
   int            resp_id_q[$];
   int            resp_cyc_q[$];
   logic [QW-1:0] resp_q_q[$];
   logic          resp_dz_q[$];

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_dividend[k*N +: N] = dvd[k];
         req_divisor[k*N +: N]  = dvs[k];
      end
   end

   divider_arbiter #(.N(N), .Q(Q), .NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) dut (
      .iClk          (clk),
      .iRst_n        (rst_n),
      .iReqValid     (req_valid),
      .iReqDividend  (req_dividend),
      .iReqDivisor   (req_divisor),
      .oReqAccept    (req_accept),
      .oRespValid    (resp_valid),
      .oRespId       (resp_id),
      .oRespQuotient (resp_quot),
      .oRespDivZero  (resp_dz),
      .oDivStart     (div_start),
      .oDivDividend  (div_dividend),
      .oDivDivisor   (div_divisor),
      .iDivQuotient  (div_q),
      .iDivComplete  (div_complete)
   );

   // Sign-magnitude fixed-point divide, {sign, 2N-bit magnitude}.
   function automatic logic [QW-1:0] div_model(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] num;
      logic [2*N-1:0] den;
      num = {{N{1'b0}}, 1'b0, a[N-2:0]} << Q;
      den = {{(N+1){1'b0}}, b[N-2:0]};
      if (den == '0) return {a[N-1] ^ b[N-1], {(2*N){1'b1}}};
      return {a[N-1] ^ b[N-1], num / den};
   endfunction

   // Divider is never reset by the arbiter reset, so it can be caught mid-operation.
   assign div_complete = (div_cnt == 0);
   always @(posedge clk) begin
      if (div_start && div_cnt == 0) begin
         div_cnt <= N + Q;
         div_q   <= div_model(div_dividend, div_divisor);
      end else if (div_cnt != 0) begin
         div_cnt <= div_cnt - 1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req_accept[k]) begin
            acc_id_q.push_back(k);
            acc_cyc_q.push_back(cyc);
         end
      end
      if (div_start) start_cyc_q.push_back(cyc);
      if (resp_valid) begin
         resp_id_q.push_back(int'(resp_id));
         resp_cyc_q.push_back(cyc);
         resp_q_q.push_back(resp_quot);
         resp_dz_q.push_back(resp_dz);
      end
   end

   task automatic check(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      acc_id_q.delete();
      acc_cyc_q.delete();
      start_cyc_q.delete();
      resp_id_q.delete();
      resp_cyc_q.delete();
      resp_q_q.delete();
      resp_dz_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Waits for accept[k], then withdraws that request before the next edge.
   task automatic wait_acc(input int k, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick(1);
         if (req_accept[k]) begin
            hit          = 1'b1;
            req_valid[k] = 1'b0;
         end
      end
      check($sformatf("acc%0d_seen", k), QW'(hit), QW'(1));
   endtask

   task automatic wait_resp(input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick(1);
         if (resp_valid) hit = 1'b1;
      end
      check("resp_seen", QW'(hit), QW'(1));
   endtask

   task automatic check_resp(input int i, input int id, input logic [QW-1:0] quot, input logic dz);
      if (i < resp_id_q.size()) begin
         check($sformatf("resp%0d_id", i), QW'(resp_id_q[i]), QW'(id));
         check($sformatf("resp%0d_quot", i), resp_q_q[i], quot);
         check($sformatf("resp%0d_dz", i), QW'(resp_dz_q[i]), QW'(dz));
      end
   endtask

   initial begin
      int exp_order[5];
      logic [QW-1:0] exp_q[NUM_REQ];
      int min_gap;
      int early;
      bit hit;
      logic prev_c;

      exp_order = '{0, 1, 2, 3, 0};
      exp_q     = '{Q_2_0, Q_0_5, Q_NEG6, Q_0_75};
      rst_n     = 1'b0;
      req_valid = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         dvd[k] = '0;
         dvs[k] = '0;
      end

      // Reset state
      tick(3);
      check("rst_accept", QW'(req_accept), QW'(0));
      check("rst_resp_valid", QW'(resp_valid), QW'(0));
      check("rst_resp_quot", resp_quot, QW'(0));
      check("rst_resp_id", QW'(resp_id), QW'(0));
      check("rst_div_start", QW'(div_start), QW'(0));
      check("rst_div_operands", QW'({div_dividend, div_divisor}), QW'(0));
      rst_n = 1'b1;
      tick(2);

      // Single request 6.0 / 3.0
      clear_q();
      dvd[0] = 32'h0003_0000;
      dvs[0] = 32'h0001_8000;
      req_valid[0] = 1'b1;
      wait_acc(0, 10);
      wait_resp(80);
      check("t1_acc_count", QW'(acc_id_q.size()), QW'(1));
      check("t1_start_count", QW'(start_cyc_q.size()), QW'(1));
      if (acc_cyc_q.size() > 0 && start_cyc_q.size() > 0)
         check("t1_start_lat", QW'(start_cyc_q[0] - acc_cyc_q[0]), QW'(1));
      if (acc_cyc_q.size() > 0 && resp_cyc_q.size() > 0)
         check("t1_resp_lat", QW'(resp_cyc_q[0] - acc_cyc_q[0]), QW'(LAT));
      check_resp(0, 0, Q_2_0, 1'b0);
      tick(2);

      // All four requesting continuously from reset
      rst_n = 1'b0;
      tick(2);
      clear_q();
      dvd = '{32'h0003_0000, 32'h0000_8000, 32'h8003_0000, 32'h0001_8000};
      dvs = '{32'h0001_8000, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000};
      req_valid = '1;
      rst_n = 1'b1;
      for (int i = 0; i < 5 * 60 && acc_id_q.size() < 5; i++) tick(1);
      req_valid = '0;
      for (int i = 0; i < 80 && resp_id_q.size() < 5; i++) tick(1);
      check("t2_acc_count", QW'(acc_id_q.size()), QW'(5));
      check("t2_resp_count", QW'(resp_id_q.size()), QW'(5));
      for (int i = 0; i < acc_id_q.size() && i < 5; i++)
         check($sformatf("t2_acc%0d_id", i), QW'(acc_id_q[i]), QW'(exp_order[i]));
      for (int i = 0; i < 5; i++) check_resp(i, exp_order[i], exp_q[exp_order[i]], 1'b0);
      min_gap = 1000;
      for (int i = 1; i < start_cyc_q.size(); i++)
         if (start_cyc_q[i] - start_cyc_q[i-1] < min_gap) min_gap = start_cyc_q[i] - start_cyc_q[i-1];
      check("t2_start_gap", QW'(min_gap >= int'(N + Q + 4)), QW'(1));
      tick(3);

      // Negative-zero divisor on requester 2
      clear_q();
      dvd[2] = 32'h0003_0000;
      dvs[2] = 32'h8000_0000;
      req_valid[2] = 1'b1;
      wait_acc(2, 10);
      wait_resp(10);
      if (acc_cyc_q.size() > 0 && resp_cyc_q.size() > 0)
         check("t3_resp_lat", QW'(resp_cyc_q[0] - acc_cyc_q[0]), QW'(1));
      check_resp(0, 2, Q_SATNEG, 1'b1);
      tick(4);
      check("t3_no_start", QW'(start_cyc_q.size()), QW'(0));

      // Reset during BUSY while the divider keeps counting
      dvd[0] = 32'h0003_0000;
      dvs[0] = 32'h0001_8000;
      req_valid[0] = 1'b1;
      wait_acc(0, 10);
      tick(10);
      rst_n = 1'b0;
      tick(2);
      check("t4_rst_accept", QW'(req_accept), QW'(0));
      check("t4_rst_resp_quot", resp_quot, QW'(0));
      clear_q();
      dvd[1] = 32'h0003_0000;
      dvs[1] = 32'h0001_8000;
      req_valid[1] = 1'b1;
      check("t4_div_running", QW'(div_complete), QW'(0));
      rst_n = 1'b1;
      early  = 0;
      hit    = 1'b0;
      prev_c = div_complete;
      for (int i = 0; i < 100 && !hit; i++) begin
         tick(1);
         if (req_accept != '0) begin
            hit = 1'b1;
            if (!prev_c) early++;
            req_valid[1] = 1'b0;
         end
         prev_c = div_complete;
      end
      check("t4_acc_seen", QW'(hit), QW'(1));
      check("t4_early_accepts", QW'(early), QW'(0));
      wait_resp(80);
      if (acc_id_q.size() > 0) check("t4_acc_id", QW'(acc_id_q[0]), QW'(1));
      check("t4_start_count", QW'(start_cyc_q.size()), QW'(1));
      check_resp(0, 1, Q_2_0, 1'b0);
      tick(2);

      // Short-lived req3 during BUSY, req1 waiting through BUSY
      clear_q();
      dvd[0] = 32'h0003_0000;
      dvs[0] = 32'h0001_8000;
      req_valid[0] = 1'b1;
      wait_acc(0, 10);
      tick(5);
      dvd[3] = 32'h0001_8000;
      dvs[3] = 32'h0002_0000;
      req_valid[3] = 1'b1;
      tick(1);
      req_valid[3] = 1'b0;
      tick(3);
      dvd[1] = 32'h0000_8000;
      dvs[1] = 32'h0001_0000;
      req_valid[1] = 1'b1;
      wait_resp(80);
      wait_acc(1, 5);
      wait_resp(80);
      check("t5_acc_count", QW'(acc_id_q.size()), QW'(2));
      if (acc_id_q.size() > 1) check("t5_acc1_id", QW'(acc_id_q[1]), QW'(1));
      if (acc_cyc_q.size() > 1 && resp_cyc_q.size() > 0)
         check("t5_acc1_first_idle", QW'(acc_cyc_q[1] - resp_cyc_q[0]), QW'(1));
      check_resp(0, 0, Q_2_0, 1'b0);
      check_resp(1, 1, Q_0_5, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
